latch_write_sequencer: RTL and testbench
========================================

# latch_write_sequencer

Upstream driver for the team's transparent D latch (`d`/`en`/active-low `rstn`/`q`). It accepts data words over a valid/ready handshake and drives the latch pins with guaranteed setup, open and hold windows, so that `d` never changes while `en` is high. It also issues latch clears on request and reads `q` back to flag write failures. It sits between synchronous control logic and the asynchronous latch, and is the only block allowed to toggle the latch pins.

## Interface
Parameters:
- `WIDTH`, 1: data width (latch `d`/`q` width).
- `SETUP_CYC`, 2: cycles `lat_d` is stable before `lat_en` rises (≥1).
- `OPEN_CYC`, 3: cycles `lat_en` stays high (≥1).
- `HOLD_CYC`, 1: cycles `lat_d` is held after `lat_en` falls (≥1).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  write request.
- `in_ready`  out  1  block can accept a write this cycle.
- `in_data`  in  WIDTH  word to latch.
- `clr_req`  in  1  request a latch clear (level, sampled in IDLE only).
- `lat_d`  out  WIDTH  to latch `d`, registered.
- `lat_en`  out  1  to latch `en`, registered.
- `lat_rstn`  out  1  to latch `rstn`, registered, active-low.
- `lat_q`  in  WIDTH  latch `q` readback.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a write or clear completes.
- `err`  out  1  sticky readback mismatch.

## Operation
- States: IDLE, CLEAR, SETUP, OPEN, HOLD. Each timed state loads a down-counter with N−1 on entry and exits when the counter is 0.
- IDLE: `in_ready` = (state==IDLE) && !`clr_req`, which is combinational. `clr_req` has priority over `in_valid`.
  - Clear goes to CLEAR.
  - Accept (`in_valid && in_ready`) registers `in_data` into `lat_d` and goes to SETUP.
- CLEAR: lasts 1 cycle. `lat_rstn`=0, `lat_d`=0, `lat_en`=0. Then IDLE with `done`=1.
- SETUP: `lat_en`=0 for `SETUP_CYC` cycles, then OPEN.
- OPEN: `lat_en`=1 for `OPEN_CYC` cycles, then HOLD.
- HOLD: `lat_en`=0 for `HOLD_CYC` cycles.
  - In the last HOLD cycle, compare `lat_q` with `lat_d`. A mismatch sets `err`.
  - Then IDLE with `done`=1.
- `lat_d` changes only on the accept edge or on CLEAR entry. It is constant through SETUP/OPEN/HOLD.
- `clr_req` or `in_valid` outside IDLE is ignored and not queued. `in_data` is not sampled outside the accept edge.
- `err` is cleared only by `rst`.

## Timing
- Reset values: state IDLE, `lat_d`=0, `lat_en`=0, `lat_rstn`=0, `done`=0, `err`=0, `busy`=0.
- `lat_rstn` returns to 1 at the first edge with `rst`=0, so the latch is held cleared for the whole reset period.
- Accept at edge k:
  - `lat_d` is valid after k.
  - `lat_en` is high from edge k+S to k+S+O.
  - IDLE is re-entered with `done`=1 at edge k+S+O+H.
  - The earliest next accept is edge k+S+O+H+1.
  - Back-to-back write period is S+O+H+1 cycles (7 with defaults).
- `lat_en` and `lat_d` never change on the same edge. `lat_en` is never high in CLEAR.
- `rst` mid-transaction: at the next edge, `lat_en`=0, `lat_rstn`=0, state IDLE. The partial write is discarded with no `done`.
- `clr_req` and `in_valid` together in IDLE: clear wins and `in_ready`=0 that cycle.

## Structure
- Shared package `latch_seq_pkg`:
  - state enum (`IDLE`, `CLEAR`, `SETUP`, `OPEN`, `HOLD`);
  - function `cnt_w(max)` = clog2 of max(`SETUP_CYC`,`OPEN_CYC`,`HOLD_CYC`), min 1.
- One natural sub-module: `phase_timer`, a loadable down-counter with a `zero` flag, reused for all three timed phases.
- Integration bench instantiates this block driving the existing D latch directly.

## Test plan
- Reset, then idle: during `rst`, `lat_rstn`=0 and `lat_en`=0. One edge after `rst` falls, `lat_rstn`=1. `in_ready`=1.
- Single write, WIDTH=4, S=2/O=3/H=1, `in_data`=4'hA accepted at edge k:
  - `lat_en` high exactly for edges k+2..k+5;
  - `done` pulse at k+6;
  - latch `q`=4'hA;
  - `err`=0.
- Back-to-back writes 4'h3, 4'h5 with `in_valid` held: second accept 7 cycles after the first. `lat_d` is stable while `lat_en`=1.
- Clear and write both requested in IDLE with 4'hF: CLEAR taken, `lat_rstn` low for 1 cycle, `q`=0, `done` pulse. The write is accepted on the following cycle.
- Readback fault (force `lat_q`=4'h0 while writing 4'h6): `err` rises after the last HOLD cycle and stays set until `rst`.
- `rst` asserted during OPEN: next edge `lat_en`=0, `lat_rstn`=0, `busy`=0, and no `done` pulse.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// Shared types and sizing helpers for the latch write sequencer.
// No logic; no backpressure.
package latch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SETUP = 3'd2,
    OPEN  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width for the longest phase; a 1-cycle phase still needs one bit.
  function automatic int cnt_w(input int max);
    return (max <= 1) ? 1 : $clog2(max);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag, shared by the SETUP/OPEN/HOLD phases.
// Load takes effect next cycle; counts down to 0 and parks there; no backpressure.
module phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Drives a transparent D latch with setup/open/hold windows; issues clears; flags readback errors.
// Write takes SETUP+OPEN+HOLD cycles to done; in_ready is low whenever not IDLE or a clear is requested.
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int SETUP_CYC = 2,
  parameter int OPEN_CYC  = 3,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_req,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             lat_rstn,
  input  logic [WIDTH-1:0] lat_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = cnt_w(max3(SETUP_CYC, OPEN_CYC, HOLD_CYC));
  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] O_LD = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

  state_t        state;
  logic          t_load;
  logic [CW-1:0] t_val;
  logic          t_zero;

  assign in_ready = (state == IDLE) && !clr_req;
  assign busy     = (state != IDLE);

  // Timer is reloaded on the edge that enters each timed phase.
  always_comb begin
    t_load = 1'b0;
    t_val  = S_LD;
    case (state)
      IDLE: begin
        if (in_ready && in_valid) begin
          t_load = 1'b1;
          t_val  = S_LD;
        end
      end
      SETUP: begin
        if (t_zero) begin
          t_load = 1'b1;
          t_val  = O_LD;
        end
      end
      OPEN: begin
        if (t_zero) begin
          t_load = 1'b1;
          t_val  = H_LD;
        end
      end
      default: begin
        t_load = 1'b0;
        t_val  = S_LD;
      end
    endcase
  end

  phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_d    <= '0;
      lat_en   <= 1'b0;
      lat_rstn <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      lat_rstn <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            lat_rstn <= 1'b0;
            lat_d    <= '0;
            lat_en   <= 1'b0;
          end else if (in_valid) begin
            state <= SETUP;
            lat_d <= in_data;
          end
        end
        CLEAR: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        SETUP: begin
          if (t_zero) begin
            state  <= OPEN;
            lat_en <= 1'b1;
          end
        end
        OPEN: begin
          if (t_zero) begin
            state  <= HOLD;
            lat_en <= 1'b0;
          end
        end
        HOLD: begin
          if (t_zero) begin
            state <= IDLE;
            done  <= 1'b1;
            if (lat_q != lat_d) err <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          lat_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench: sequencer driving a behavioural D latch, checked every cycle against a timeline model.
module tb_latch_write_sequencer;

  localparam int W = 4;
  localparam int S = 2;
  localparam int O = 3;
  localparam int H = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         clr_req = 1'b0;
  logic [W-1:0] lat_d;
  logic         lat_en;
  logic         lat_rstn;
  logic [W-1:0] lat_q;
  logic         busy;
  logic         done;
  logic         err;

  logic [W-1:0] latch_q;
  logic         fault = 1'b0;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;
  int acc_q[$];

  always #5 clk = ~clk;

  latch_write_sequencer #(
    .WIDTH(W), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .clr_req  (clr_req),
    .lat_d    (lat_d),
    .lat_en   (lat_en),
    .lat_rstn (lat_rstn),
    .lat_q    (lat_q),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // The latch being driven: transparent while en, async active-low clear.
  always_latch begin
    if (!lat_rstn)   latch_q <= '0;
    else if (lat_en) latch_q <= lat_d;
  end
  assign lat_q = fault ? '0 : latch_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, ecnt);
    end
  endtask

  // Timeline model: a transaction starting at edge st ends (IDLE again) at edge end_e.
  localparam int K_NONE = 0, K_WR = 1, K_CLR = 2;
  int           kind  = K_NONE;
  int           st    = 0;
  int           end_e = 0;
  logic [W-1:0] m_d   = '0;
  logic         m_err = 1'b0;
  logic         m_rst;

  initial begin : compare
    logic rst_s, vld_s, rdy_s, clr_s;
    logic [W-1:0] dat_s, q_s;
    int e_en, e_rstn, e_done, e_busy, e_rdy;
    forever begin
      @(posedge clk);
      rst_s = rst; vld_s = in_valid; rdy_s = in_ready;
      clr_s = clr_req; dat_s = in_data; q_s = lat_q;
      ecnt++;
      if (vld_s && rdy_s) acc_q.push_back(ecnt);
      m_rst = rst_s;
      if (rst_s) begin
        kind = K_NONE; end_e = ecnt; m_d = '0; m_err = 1'b0;
      end else if (ecnt > end_e) begin
        if (clr_s) begin
          kind = K_CLR; st = ecnt; end_e = ecnt + 1; m_d = '0;
        end else if (vld_s) begin
          kind = K_WR; st = ecnt; end_e = ecnt + S + O + H; m_d = dat_s;
        end
      end else if (kind == K_WR && ecnt == end_e && q_s != m_d) begin
        m_err = 1'b1;
      end
      e_en   = (!m_rst && kind == K_WR && ecnt >= st + S && ecnt < st + S + O) ? 1 : 0;
      e_rstn = (m_rst || (kind == K_CLR && ecnt == st)) ? 0 : 1;
      e_done = (!m_rst && kind != K_NONE && ecnt == end_e) ? 1 : 0;
      e_busy = (ecnt < end_e) ? 1 : 0;
      #1;
      e_rdy  = (ecnt >= end_e && !clr_req) ? 1 : 0;
      chk("lat_d",    int'(lat_d), int'(m_d));
      chk("lat_en",   int'(lat_en), e_en);
      chk("lat_rstn", int'(lat_rstn), e_rstn);
      chk("done",     int'(done), e_done);
      chk("busy",     int'(busy), e_busy);
      chk("err",      int'(err), int'(m_err));
      chk("in_ready", int'(in_ready), e_rdy);
    end
  end

  task automatic write1(input logic [W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int de);
    int n;
    de = -1;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        de = ecnt;
        break;
      end
    end
    if (de < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin : stim
    int a0, de, n0, ce;
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_rstn", int'(lat_rstn), 0);
    chk("rst_en",   int'(lat_en), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstn_after_rst", int'(lat_rstn), 1);
    chk("ready_idle",     int'(in_ready), 1);

    // Single write 4'hA
    n0 = acc_q.size();
    write1(4'hA);
    a0 = (acc_q.size() > n0) ? acc_q[n0] : -100;
    wait_done("single", de);
    chk("single_latency", de - a0, 6);
    chk("single_q",   int'(latch_q), 4'hA);
    chk("single_err", int'(err), 0);

    // Back-to-back 3 then 5 with valid held
    @(negedge clk);
    n0 = acc_q.size();
    in_valid = 1'b1;
    in_data  = 4'h3;
    @(negedge clk);
    in_data  = 4'h5;
    for (int i = 0; i < 20 && acc_q.size() < n0 + 2; i++) @(negedge clk);
    in_valid = 1'b0;
    if (acc_q.size() >= n0 + 2) chk("b2b_period", acc_q[n0+1] - acc_q[n0], 7);
    else chk("b2b_timeout", 0, 1);
    wait_done("b2b", de);
    chk("b2b_q", int'(latch_q), 4'h5);

    // Clear and write together
    @(negedge clk);
    n0 = acc_q.size();
    clr_req  = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    #1;
    chk("clr_ready_low", int'(in_ready), 0);
    @(negedge clk);
    ce = ecnt;
    clr_req = 1'b0;
    chk("clr_q", int'(latch_q), 0);
    chk("clr_rstn", int'(lat_rstn), 0);
    @(negedge clk);
    chk("clr_done", int'(done), 1);
    for (int i = 0; i < 10 && acc_q.size() <= n0; i++) @(negedge clk);
    in_valid = 1'b0;
    if (acc_q.size() > n0) chk("clr_then_acc", acc_q[n0] - ce, 2);
    else chk("clr_acc_timeout", 0, 1);
    wait_done("clrwr", de);
    chk("clrwr_q", int'(latch_q), 4'hF);

    // Readback fault
    fault = 1'b1;
    write1(4'h6);
    wait_done("fault", de);
    fault = 1'b0;
    chk("fault_err", int'(err), 1);
    write1(4'hA);
    wait_done("sticky", de);
    chk("sticky_err", int'(err), 1);

    // Reset during OPEN
    write1(4'h9);
    for (int i = 0; i < 10 && !lat_en; i++) @(negedge clk);
    chk("open_reached", int'(lat_en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_en",   int'(lat_en), 0);
    chk("midrst_rstn", int'(lat_rstn), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_err", int'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
